dot_product_driver: RTL
=======================

Name: dot_product_driver

Overview:
- Feeds the registered 4-element dot-product unit, which takes two 4-bit vectors and has a 2-edge input-to-output latency.
- Collects operands from an upstream 4-bit serial stream using a valid/ready handshake, then presents all eight operands in parallel.
- Waits out the unit's latency, captures its 10-bit result, and returns that result downstream through a valid/ready handshake.
- Sits between a serial control/data source and the dot-product datapath: it drives that datapath's operand inputs and consumes its output.

Parameters:
DATA_W, 4, width of each operand beat and each parallel operand output
OUT_W, 10, width of the dot-product result (2*DATA_W+2)
LATENCY, 2, number of clock edges from stable operands to a valid i_dp_out

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous active-high reset
i_valid  in  1  upstream operand beat valid
i_data  in  DATA_W  operand beat; beat order a,b,c,d,e,f,g,h
o_ready  out  1  block accepts a beat this cycle
o_a..o_h  out  DATA_W each  parallel operands to the dot-product unit (eight ports)
i_dp_out  in  OUT_W  result from the dot-product unit
o_result  out  OUT_W  captured result
o_res_valid  out  1  o_result valid
i_res_ready  in  1  downstream accepts the result
o_busy  out  1  high in WAIT and RESULT states

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state=LOAD, beat_cnt=0, wait_cnt=0, o_a..o_h=0, o_result=0, o_res_valid=0, o_busy=0, o_ready=1 combinationally in LOAD.
- States: LOAD, WAIT, RESULT. There is no separate idle state; LOAD with beat_cnt=0 is idle.
- LOAD:
  - o_ready=1.
  - A beat is accepted when i_valid and o_ready are both high on a rising edge.
  - An accepted beat writes i_data into the operand selected by beat_cnt (0->o_a ... 7->o_h), then beat_cnt increments.
  - i_valid low is a bubble: nothing changes, and gaps of any length are allowed.
  - On acceptance of beat 7: beat_cnt->0, wait_cnt->0, state->WAIT.
- Operand outputs:
  - Each operand output is a register and updates only on the edge its beat is accepted.
  - Operands hold their value through WAIT and RESULT until overwritten in the next LOAD pass.
- WAIT:
  - o_ready=0 and o_busy=1.
  - wait_cnt increments on every edge.
  - Let E0 be the edge that accepted beat 7. i_dp_out is sampled into o_result on edge E0+LATENCY+1, which is the edge where wait_cnt==LATENCY.
  - On that same edge o_res_valid->1 and state->RESULT.
  - With LATENCY=2: the unit captures operands at E0+1, its output updates at E0+2, and this block captures at E0+3.
- RESULT:
  - o_ready=0, o_busy=1, and o_result is held stable.
  - The handshake completes when o_res_valid and i_res_ready are both high on an edge. On that edge o_res_valid->0, state->LOAD, and o_busy->0.
  - The first beat of the next vector can be accepted no earlier than the following edge, because o_ready is 0 in RESULT.
  - i_res_ready held low stalls indefinitely with o_result held; upstream beats are not accepted.
- i_res_ready high in LOAD or WAIT has no effect.
- Arithmetic: none inside this block. o_result is an exact copy of i_dp_out, so the maximum value 4*15*15=900 fits in OUT_W=10.
- Reset mid-operation (any state, any beat_cnt or wait_cnt):
  - All registers return to their reset values on the next edge.
  - A partial vector is discarded and a pending result is dropped.
  - A beat presented in the same cycle as reset is not accepted.
- Throughput: 8 load edges + LATENCY+1 wait edges + ≥1 result edge per vector, i.e. 12 cycles minimum at LATENCY=2.

Test Plan:
- Reset, then stream 1,2,3,4,5,6,7,8 back-to-back with i_res_ready=1 -> o_a..o_h=1..8, o_res_valid rises exactly 3 edges after beat 8, o_result=70 (5+12+21+32), o_busy falls one edge later.
- All beats 15 -> o_result=900 (10'h384), no truncation.
- Random i_valid bubbles between beats of 2,0,3,1,4,5,6,7 -> o_result=2*4+0*5+3*6+1*7=33; o_ready never drops in LOAD; beat order unaffected by gaps.
- Hold i_res_ready=0 for 20 cycles in RESULT while upstream keeps i_valid=1 -> o_result stable, o_ready=0, no beats consumed; first beat accepted on the edge after the handshake.
- Assert i_rst after beat 5, then send a full vector of all 1s -> operands cleared at reset, next o_result=4, no spurious o_res_valid.
- Assert i_rst while in RESULT with o_res_valid=1 -> o_res_valid=0 and o_result=0 on the next edge, state returns to LOAD, o_ready=1.

Source files
------------

// File: rtl/dot_product_driver.sv
// rtl/dot_product_driver.sv - serial-to-parallel operand loader and result catcher for a registered dot-product unit
//
// Purpose:
//   Collects eight DATA_W-bit operand beats (order a..h) from an upstream
//   valid/ready stream and presents them in parallel on o_a..o_h. It then
//   waits out the dot-product unit's LATENCY and captures i_dp_out into
//   o_result. The result is offered downstream through a valid/ready
//   handshake.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_valid      upstream operand beat valid
//   i_data       operand beat, order a,b,c,d,e,f,g,h
//   o_ready      high while loading operands (combinational from state)
//   o_a..o_h     registered parallel operands to the dot-product unit
//   i_dp_out     result from the dot-product unit
//   o_result     captured result, held until the next capture or reset
//   o_res_valid  o_result valid
//   i_res_ready  downstream accepts the result
//   o_busy       high while waiting for or presenting a result

module dot_product_driver #(
  parameter int DATA_W  = 4,
  parameter int OUT_W   = 10,
  parameter int LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [DATA_W-1:0] o_c,
  output logic [DATA_W-1:0] o_d,
  output logic [DATA_W-1:0] o_e,
  output logic [DATA_W-1:0] o_f,
  output logic [DATA_W-1:0] o_g,
  output logic [DATA_W-1:0] o_h,
  input  logic [OUT_W-1:0]  i_dp_out,
  output logic [OUT_W-1:0]  o_result,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_busy
);

  // Wide enough to hold LATENCY itself, which is the terminal count.
  localparam int WAIT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WAIT   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        beat_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  // Ready is a pure function of state so a beat offered in the first LOAD
  // cycle after reset or after a handshake is taken without delay.
  assign o_ready = (state == LOAD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= LOAD;
      beat_cnt    <= 3'd0;
      wait_cnt    <= '0;
      o_a         <= '0;
      o_b         <= '0;
      o_c         <= '0;
      o_d         <= '0;
      o_e         <= '0;
      o_f         <= '0;
      o_g         <= '0;
      o_h         <= '0;
      o_result    <= '0;
      o_res_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // i_valid low is a bubble: nothing moves.
          if (i_valid) begin
            case (beat_cnt)
              3'd0: o_a <= i_data;
              3'd1: o_b <= i_data;
              3'd2: o_c <= i_data;
              3'd3: o_d <= i_data;
              3'd4: o_e <= i_data;
              3'd5: o_f <= i_data;
              3'd6: o_g <= i_data;
              3'd7: o_h <= i_data;
            endcase
            if (beat_cnt == 3'd7) begin
              beat_cnt <= 3'd0;
              wait_cnt <= '0;
              o_busy   <= 1'b1;
              state    <= WAIT;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end

        WAIT: begin
          // The edge after the last beat lets the unit register the
          // operands; LATENCY more edges later its output is settled, so
          // the capture lands on the edge where wait_cnt reaches LATENCY.
          if (wait_cnt == WAIT_LAST) begin
            o_result    <= i_dp_out;
            o_res_valid <= 1'b1;
            wait_cnt    <= '0;
            state       <= RESULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESULT: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            o_busy      <= 1'b0;
            state       <= LOAD;
          end
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
